imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//   Writer side of the instruction memory that fetch_Cycle reads. Takes a byte stream
//   (valid/ready), packs bytes big-endian into 32-bit words and writes them to
//   consecutive instruction-memory addresses.
//   Holds the pipeline in reset via cpu_hold until a complete image is written.
// PARAMETERS
//   ADDR_W     5    instruction-memory word-address width (matches 5-bit PC)
//   DEPTH      32   number of writable words; legal word counts are 0..DEPTH
//   BASE_ADDR  0    word address of the first word written
// PORTS
//   clk         in   1       clock
//   reset       in   1       asynchronous, active-high reset
//   load_start  in   1       1-cycle pulse: begin a load; honoured in IDLE/DONE/ERR only
//   in_valid    in   1       byte-stream valid
//   in_data     in   8       byte-stream data
//   in_ready    out  1       byte accepted when in_valid & in_ready on a rising clk edge
//   imem_we     out  1       instruction-memory write strobe (1-cycle pulse)
//   imem_addr   out  ADDR_W  instruction-memory write word address
//   imem_wdata  out  32      instruction-memory write data
//   cpu_hold    out  1       1 = pipeline held in reset; OR this into the pipeline reset
//   done        out  1       image loaded successfully (sticky)
//   error       out  1       load aborted (sticky)
// BEHAVIOUR
//   Reset values: in_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0,
//     cpu_hold=1, done=0, error=0, state=IDLE.
//   Stream format: CNT_HI, CNT_LO (16-bit word count N), then N*4 data bytes, MSB first.
//   FSM: IDLE -load_start-> LEN -2 bytes-> (N==0 ? DONE : N>DEPTH ? ERR : DATA)
//     DATA -N words written-> DONE (or CSUM when CHECKSUM_EN is defined)
//     DONE/ERR -load_start-> LEN
//   in_ready=1 only in LEN, DATA, CSUM.
//   A load_start pulse seen while in LEN, DATA or CSUM is ignored.
//   Entering LEN: cpu_hold=1, done=0, error=0, byte counter=0, imem_addr=BASE_ADDR.
//   Word assembly: a byte shift register takes each accepted byte.
//   On the accepted 4th byte of a word, next cycle: imem_we=1 and imem_wdata=the packed word.
//   imem_addr is the address of that word.
//   imem_addr increments in the cycle after each write pulse; no wrap, because N<=DEPTH.
//   in_ready stays 1 during the write pulse, so a throughput of 1 byte/clk is sustained.
//   Words never overlap, since the next write needs 4 more bytes.
//   N>DEPTH: enter ERR right after CNT_LO; error=1, no writes issued, cpu_hold stays 1.
//   DONE: cpu_hold=0, done=1, in_ready=0.
//   cpu_hold falls in the same cycle as done rises, i.e. the cycle after the last write pulse.
//   in_valid gaps: state and counters are held; no timeout.
//   Reset mid-load: abort immediately to reset values. A partial image is left in memory.
// CONFIGURATION
//   CHECKSUM_EN defined: after the last data byte the FSM enters CSUM and accepts 1 byte.
//     That byte must equal the XOR of all N*4 data bytes (running XOR starts at 0x00 in LEN).
//     Match -> DONE. Mismatch -> ERR: error=1 and cpu_hold stays 1.
//     Words already written are not undone.
//     With N==0 the CSUM byte is still required and must be 0x00.
//   CHECKSUM_EN undefined: no CSUM state; DATA goes directly to DONE; bytes after the
//     image are not accepted (in_ready=0).
// TESTING
//   1. Reset, then load_start; stream 00 01 12 34 56 78.
//      -> one imem_we pulse, addr 0, wdata 0x12345678; next cycle done=1, cpu_hold=0.
//   2. N=3, bytes streamed back-to-back with in_valid held at 1.
//      -> writes at addr 0,1,2, each the cycle after its 4th byte; in_ready never drops.
//   3. Count 00 21 (33 > DEPTH).
//      -> error=1, no imem_we, cpu_hold=1, in_ready=0; then load_start with N=1 -> done.
//   4. Assert reset after 6 data bytes of an N=2 load.
//      -> all outputs at reset values; addr 0 holds word 0; cpu_hold=1.
//   5. Random in_valid gaps, plus a load_start pulse during DATA.
//      -> identical memory contents to test 2; the load_start pulse has no effect.
//   6. CHECKSUM_EN: image 00 01 01 02 03 04, CSUM 04 -> done=1; CSUM 05 -> error=1,
//      cpu_hold=1.

Source files
------------

// File: rtl/imem_loader.sv
// Byte-stream loader for the instruction memory: packs big-endian words, holds the CPU until done.
// Optional trailing XOR checksum byte when CHECKSUM_EN is defined.
module imem_loader #(
   parameter int ADDR_W    = 5,
   parameter int DEPTH     = 32,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_hold,
   output logic              done,
   output logic              error
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN,
      S_DATA,
`ifdef CHECKSUM_EN
      S_CSUM,
`endif
      S_DONE,
      S_ERR
   } state_t;

   state_t             state_reg, state_next;
   logic [1:0]         byte_cnt_reg, byte_cnt_next;
   logic [15:0]        word_cnt_reg, word_cnt_next;
   logic [15:0]        n_reg, n_next;
   logic [15:0]        n_full;
   logic [23:0]        shift_reg, shift_next;
   logic               we_reg, we_next;
   logic [ADDR_W-1:0]  addr_reg, addr_next;
   logic [31:0]        wdata_reg, wdata_next;
   logic               hold_reg, hold_next;
   logic               done_reg, done_next;
   logic               error_reg, error_next;
`ifdef CHECKSUM_EN
   logic [7:0]         csum_reg, csum_next;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg    <= S_IDLE;
         byte_cnt_reg <= 2'd0;
         word_cnt_reg <= 16'd0;
         n_reg        <= 16'd0;
         shift_reg    <= 24'd0;
         we_reg       <= 1'b0;
         addr_reg     <= ADDR_W'(BASE_ADDR);
         wdata_reg    <= 32'd0;
         hold_reg     <= 1'b1;
         done_reg     <= 1'b0;
         error_reg    <= 1'b0;
`ifdef CHECKSUM_EN
         csum_reg     <= 8'd0;
`endif
      end else begin
         state_reg    <= state_next;
         byte_cnt_reg <= byte_cnt_next;
         word_cnt_reg <= word_cnt_next;
         n_reg        <= n_next;
         shift_reg    <= shift_next;
         we_reg       <= we_next;
         addr_reg     <= addr_next;
         wdata_reg    <= wdata_next;
         hold_reg     <= hold_next;
         done_reg     <= done_next;
         error_reg    <= error_next;
`ifdef CHECKSUM_EN
         csum_reg     <= csum_next;
`endif
      end
   end

   always_comb begin
      state_next    = state_reg;
      byte_cnt_next = byte_cnt_reg;
      word_cnt_next = word_cnt_reg;
      n_next        = n_reg;
      n_full        = {n_reg[15:8], in_data};
      shift_next    = shift_reg;
      we_next       = 1'b0;
      addr_next     = we_reg ? addr_reg + ADDR_W'(1) : addr_reg;
      wdata_next    = wdata_reg;
      hold_next     = hold_reg;
      done_next     = done_reg;
      error_next    = error_reg;
`ifdef CHECKSUM_EN
      csum_next     = csum_reg;
`endif
      in_ready      = 1'b0;

      case (state_reg)
         S_IDLE, S_DONE, S_ERR: begin
            if (load_start) begin
               state_next    = S_LEN;
               hold_next     = 1'b1;
               done_next     = 1'b0;
               error_next    = 1'b0;
               byte_cnt_next = 2'd0;
               word_cnt_next = 16'd0;
               addr_next     = ADDR_W'(BASE_ADDR);
`ifdef CHECKSUM_EN
               csum_next     = 8'd0;
`endif
            end
         end

         S_LEN: begin
            in_ready = 1'b1;
            if (in_valid) begin
               if (byte_cnt_reg == 2'd0) begin
                  n_next[15:8]  = in_data;
                  byte_cnt_next = 2'd1;
               end else begin
                  n_next        = n_full;
                  byte_cnt_next = 2'd0;
                  if (n_full == 16'd0) begin
`ifdef CHECKSUM_EN
                     state_next = S_CSUM;
`else
                     state_next = S_DONE;
                     done_next  = 1'b1;
                     hold_next  = 1'b0;
`endif
                  end else if (n_full > 16'(DEPTH)) begin
                     state_next = S_ERR;
                     error_next = 1'b1;
                  end else begin
                     state_next = S_DATA;
                  end
               end
            end
         end

         S_DATA: begin
            // Stop accepting once all N words are in; the final write pulse may still be pending.
            in_ready = (word_cnt_reg != n_reg);
            if (in_valid && in_ready) begin
`ifdef CHECKSUM_EN
               csum_next = csum_reg ^ in_data;
`endif
               if (byte_cnt_reg == 2'd3) begin
                  wdata_next    = {shift_reg, in_data};
                  we_next       = 1'b1;
                  byte_cnt_next = 2'd0;
                  word_cnt_next = word_cnt_reg + 16'd1;
`ifdef CHECKSUM_EN
                  if (word_cnt_reg + 16'd1 == n_reg)
                     state_next = S_CSUM;
`endif
               end else begin
                  shift_next    = {shift_reg[15:0], in_data};
                  byte_cnt_next = byte_cnt_reg + 2'd1;
               end
            end
`ifndef CHECKSUM_EN
            if (we_reg && word_cnt_reg == n_reg) begin
               state_next = S_DONE;
               done_next  = 1'b1;
               hold_next  = 1'b0;
            end
`endif
         end

`ifdef CHECKSUM_EN
         S_CSUM: begin
            in_ready = 1'b1;
            if (in_valid) begin
               if (in_data == csum_reg) begin
                  state_next = S_DONE;
                  done_next  = 1'b1;
                  hold_next  = 1'b0;
               end else begin
                  state_next = S_ERR;
                  error_next = 1'b1;
               end
            end
         end
`endif

         default: state_next = S_IDLE;
      endcase
   end

   assign imem_we    = we_reg;
   assign imem_addr  = addr_reg;
   assign imem_wdata = wdata_reg;
   assign cpu_hold   = hold_reg;
   assign done       = done_reg;
   assign error      = error_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: load, back-to-back, oversize count, mid-load reset, gaps,
// and the checksum byte when CHECKSUM_EN is defined.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        reset;
   logic        load_start;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        imem_we;
   logic [4:0]  imem_addr;
   logic [31:0] imem_wdata;
   logic        cpu_hold;
   logic        done;
   logic        error;

   imem_loader #(.ADDR_W(5), .DEPTH(32), .BASE_ADDR(0)) dut (
      .clk        (clk),
      .reset      (reset),
      .load_start (load_start),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .cpu_hold   (cpu_hold),
      .done       (done),
      .error      (error)
   );

   always #5 clk = ~clk;

   int          tests_run = 0;
   int          tests_failed = 0;
   int          cyc = 0;
   int          done_cyc;
   logic        hold_at_done;
   logic        done_d = 1'b0;
   int          stall_cnt;
   logic [31:0] mem [0:31];
   logic [31:0] img [0:3];
   logic [7:0]  stim [$];
   int          acc_cyc [$];
   int          wr_cyc [$];
   logic [4:0]  wr_addr [$];
   logic [31:0] wr_data [$];

   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural instruction memory plus a write log, sampled mid-cycle.
   always @(negedge clk) begin
      if (imem_we) begin
         mem[imem_addr] = imem_wdata;
         wr_addr.push_back(imem_addr);
         wr_data.push_back(imem_wdata);
         wr_cyc.push_back(cyc);
      end
      if (done && !done_d) begin
         done_cyc     = cyc;
         hold_at_done = cpu_hold;
      end
      done_d = done;
   end

   task automatic clear_log();
      wr_addr.delete(); wr_data.delete(); wr_cyc.delete(); acc_cyc.delete();
      for (int i = 0; i < 32; i++) mem[i] = 32'd0;
      done_cyc  = -1;
      stall_cnt = 0;
   endtask

   task automatic build_image(input int n);
      logic [7:0] x;
      logic [7:0] b;
      logic [31:0] w;
      x = 8'd0;
      stim.delete();
      stim.push_back(8'(n >> 8));
      stim.push_back(8'(n));
      for (int i = 0; i < n; i++) begin
         w = img[i];
         for (int k = 3; k >= 0; k--) begin
            b = w[8*k +: 8];
            stim.push_back(b);
            x = x ^ b;
         end
      end
`ifdef CHECKSUM_EN
      stim.push_back(x);
`endif
   endtask

   task automatic pulse_load();
      load_start = 1'b1;
      @(negedge clk);
      load_start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int t;
      t = 0;
      in_valid = 1'b1;
      in_data  = b;
      while (!in_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) begin
         tests_run++;
         tests_failed++;
         $display("FAIL send_byte_timeout: in_ready=%0b required 1", in_ready);
      end
      stall_cnt += t;
      acc_cyc.push_back(cyc);
      @(negedge clk);
   endtask

   task automatic send_stream(input bit gaps, input int ls_at);
      for (int i = 0; i < stim.size(); i++) begin
         if (gaps) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
         end
         if (i == ls_at) begin
            in_valid = 1'b0;
            pulse_load();
         end
         send_byte(stim[i]);
      end
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset();
      @(negedge clk);
      tests_run++;
      if (in_ready !== 1'b0 || imem_we !== 1'b0 || imem_addr !== 5'd0 || imem_wdata !== 32'd0) begin
         tests_failed++;
         $display("FAIL reset_datapath: ready=%0b we=%0b addr=%0d wdata=%h required 0 0 0 00000000",
                  in_ready, imem_we, imem_addr, imem_wdata);
      end
      tests_run++;
      if (cpu_hold !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_status: hold=%0b done=%0b error=%0b required 1 0 0", cpu_hold, done, error);
      end
      $display("[TB] reset: hold=%0b done=%0b error=%0b", cpu_hold, done, error);
   endtask

   task automatic test_single_word();
      clear_log();
      img[0] = 32'h12345678;
      build_image(1);
      pulse_load();
      send_stream(1'b0, -1);
      tests_run++;
      if (wr_addr.size() != 1) begin
         tests_failed++;
         $display("FAIL single_write_count: got %0d required 1", wr_addr.size());
      end else begin
         tests_run++;
         if (wr_addr[0] !== 5'd0 || wr_data[0] !== 32'h12345678) begin
            tests_failed++;
            $display("FAIL single_write: addr=%0d data=%h required 0 12345678", wr_addr[0], wr_data[0]);
         end
         tests_run++;
         if (done_cyc != wr_cyc[0] + 1 || hold_at_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_done_timing: done_cyc=%0d hold=%0b required %0d 0",
                     done_cyc, hold_at_done, wr_cyc[0] + 1);
         end
      end
      tests_run++;
      if (done !== 1'b1 || cpu_hold !== 1'b0 || error !== 1'b0 || in_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL single_done_state: done=%0b hold=%0b error=%0b ready=%0b required 1 0 0 0",
                  done, cpu_hold, error, in_ready);
      end
      $display("[TB] single: writes=%0d done=%0b hold=%0b", wr_addr.size(), done, cpu_hold);
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_w [0:2];
      exp_w[0] = 32'h11223344; exp_w[1] = 32'h55667788; exp_w[2] = 32'h99AABBCC;
      clear_log();
      for (int i = 0; i < 3; i++) img[i] = exp_w[i];
      build_image(3);
      pulse_load();
      send_stream(1'b0, -1);
      tests_run++;
      if (wr_addr.size() != 3) begin
         tests_failed++;
         $display("FAIL b2b_write_count: got %0d required 3", wr_addr.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (wr_addr[i] !== 5'(i) || wr_data[i] !== exp_w[i] || wr_cyc[i] != acc_cyc[4*i+5] + 1) begin
               tests_failed++;
               $display("FAIL b2b_word%0d: addr=%0d data=%h cyc=%0d required %0d %h %0d",
                        i, wr_addr[i], wr_data[i], wr_cyc[i], i, exp_w[i], acc_cyc[4*i+5] + 1);
            end
         end
      end
      tests_run++;
      if (stall_cnt != 0 || done !== 1'b1) begin
         tests_failed++;
         $display("FAIL b2b_stalls: stalls=%0d done=%0b required 0 1", stall_cnt, done);
      end
      $display("[TB] back_to_back: writes=%0d stalls=%0d done=%0b", wr_addr.size(), stall_cnt, done);
   endtask

   task automatic test_oversize();
      clear_log();
      stim.delete();
      stim.push_back(8'h00);
      stim.push_back(8'h21);
      pulse_load();
      for (int i = 0; i < 2; i++) send_byte(stim[i]);
      in_valid = 1'b0;
      tests_run++;
      if (error !== 1'b1 || cpu_hold !== 1'b1 || in_ready !== 1'b0 || done !== 1'b0) begin
         tests_failed++;
         $display("FAIL oversize_err: error=%0b hold=%0b ready=%0b done=%0b required 1 1 0 0",
                  error, cpu_hold, in_ready, done);
      end
      repeat (3) @(negedge clk);
      tests_run++;
      if (wr_addr.size() != 0) begin
         tests_failed++;
         $display("FAIL oversize_writes: got %0d required 0", wr_addr.size());
      end
      img[0] = 32'hCAFEF00D;
      build_image(1);
      pulse_load();
      tests_run++;
      if (error !== 1'b0 || in_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL oversize_restart: error=%0b ready=%0b required 0 1", error, in_ready);
      end
      send_stream(1'b0, -1);
      tests_run++;
      if (done !== 1'b1 || mem[0] !== 32'hCAFEF00D) begin
         tests_failed++;
         $display("FAIL oversize_reload: done=%0b mem0=%h required 1 cafef00d", done, mem[0]);
      end
      $display("[TB] oversize: reload done=%0b mem0=%h", done, mem[0]);
   endtask

   task automatic test_mid_reset();
      clear_log();
      img[0] = 32'hAABBCCDD; img[1] = 32'hEEFF0102;
      build_image(2);
      pulse_load();
      for (int i = 0; i < 8; i++) send_byte(stim[i]);
      in_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      #1;
      tests_run++;
      if (in_ready !== 1'b0 || imem_we !== 1'b0 || imem_addr !== 5'd0 || imem_wdata !== 32'd0 ||
          cpu_hold !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin
         tests_failed++;
         $display("FAIL midreset_outputs: ready=%0b we=%0b addr=%0d wdata=%h hold=%0b done=%0b err=%0b required 0 0 0 0 1 0 0",
                  in_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, error);
      end
      tests_run++;
      if (mem[0] !== 32'hAABBCCDD || mem[1] !== 32'd0 || wr_addr.size() != 1) begin
         tests_failed++;
         $display("FAIL midreset_mem: mem0=%h mem1=%h writes=%0d required aabbccdd 0 1",
                  mem[0], mem[1], wr_addr.size());
      end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      $display("[TB] mid_reset: mem0=%h hold=%0b", mem[0], cpu_hold);
   endtask

   task automatic test_gaps();
      clear_log();
      img[0] = 32'h11223344; img[1] = 32'h55667788; img[2] = 32'h99AABBCC;
      build_image(3);
      pulse_load();
      send_stream(1'b1, 6);
      tests_run++;
      if (wr_addr.size() != 3 || done !== 1'b1 || error !== 1'b0) begin
         tests_failed++;
         $display("FAIL gaps_status: writes=%0d done=%0b error=%0b required 3 1 0",
                  wr_addr.size(), done, error);
      end
      tests_run++;
      if (mem[0] !== 32'h11223344 || mem[1] !== 32'h55667788 || mem[2] !== 32'h99AABBCC) begin
         tests_failed++;
         $display("FAIL gaps_mem: %h %h %h required 11223344 55667788 99aabbcc", mem[0], mem[1], mem[2]);
      end
      $display("[TB] gaps: writes=%0d mem=%h %h %h", wr_addr.size(), mem[0], mem[1], mem[2]);
   endtask

`ifdef CHECKSUM_EN
   task automatic test_checksum();
      clear_log();
      stim.delete();
      stim.push_back(8'h00); stim.push_back(8'h01);
      stim.push_back(8'h01); stim.push_back(8'h02); stim.push_back(8'h03); stim.push_back(8'h04);
      stim.push_back(8'h04);
      pulse_load();
      send_stream(1'b0, -1);
      tests_run++;
      if (done !== 1'b1 || error !== 1'b0 || cpu_hold !== 1'b0 || mem[0] !== 32'h01020304) begin
         tests_failed++;
         $display("FAIL csum_good: done=%0b err=%0b hold=%0b mem0=%h required 1 0 0 01020304",
                  done, error, cpu_hold, mem[0]);
      end
      clear_log();
      stim[6] = 8'h05;
      pulse_load();
      send_stream(1'b0, -1);
      tests_run++;
      if (done !== 1'b0 || error !== 1'b1 || cpu_hold !== 1'b1 || wr_addr.size() != 1) begin
         tests_failed++;
         $display("FAIL csum_bad: done=%0b err=%0b hold=%0b writes=%0d required 0 1 1 1",
                  done, error, cpu_hold, wr_addr.size());
      end
      $display("[TB] checksum: bad csum error=%0b hold=%0b", error, cpu_hold);
   endtask
`endif

   initial begin
      reset      = 1'b1;
      load_start = 1'b0;
      in_valid   = 1'b0;
      in_data    = 8'd0;
      clear_log();
      repeat (2) @(negedge clk);
      test_reset();
      reset = 1'b0;
      @(negedge clk);
      test_single_word();
      test_back_to_back();
      test_oversize();
      test_mid_reset();
      test_gaps();
`ifdef CHECKSUM_EN
      test_checksum();
`endif
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
